ps2_dir_decoder: RTL
====================

# ps2_dir_decoder

PS/2 keyboard receiver and key-to-direction decoder for the snake game. Sits directly upstream of the snake logic: it samples the raw `PS2C`/`PS2D` lines, deframes 11-bit scan-code frames, and tracks make/break/extended prefixes. It drives a 3-bit direction code on `kb_out`, which the game consumes.

## Interface
- `FILT_LEN`, default 8: consecutive equal samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYC`, default 50000: `clk` cycles with no filtered falling edge before a partial frame is discarded.
- `clk`  in  1  system clock; the only clock.
- `clr`  in  1  reset, synchronous, active-high.
- `PS2C`  in  1  raw PS/2 clock, asynchronous.
- `PS2D`  in  1  raw PS/2 data, asynchronous.
- `kb_out`  out  3  direction code: 000 none, 001 up, 010 down, 011 left, 100 right, 101 pause.
- `kb_strobe`  out  1  one-cycle pulse on every `kb_out` update caused by a make code.
- `frame_err`  out  1  one-cycle pulse on a start, parity or stop error.

## Operation
- **Input sync:** `PS2C` and `PS2D` each pass through a 2-flop synchronizer.
- **Clock filter:** the synced clock feeds the filter. The filtered clock changes level only after `FILT_LEN` consecutive equal samples. A falling edge is filtered clock 1 -> 0.
- **Deframing:** on each falling edge, shift synced `PS2D` into an 11-bit register, LSB first, and increment the bit counter (0..10).
- **Frame completion:** on the 11th edge the frame completes and is checked: start = 0, odd parity over data+parity = 1, stop = 1.
  - Any check fails: pulse `frame_err`, drop the byte, leave the prefix state unchanged.
- **Timeout:** the idle counter resets on each falling edge. When it reaches `TIMEOUT_CYC`, the bit counter clears to 0 and the partial frame is dropped without `frame_err`.
- **Prefix FSM** (states IDLE, EXT, BRK, EXT_BRK), advanced once per valid byte:
  - IDLE: E0 -> EXT; F0 -> BRK; other -> decode as a non-extended make, stay IDLE.
  - EXT: F0 -> EXT_BRK; other -> decode as an extended make, -> IDLE.
  - BRK: any byte -> decode as a non-extended break, -> IDLE.
  - EXT_BRK: any byte -> decode as an extended break, -> IDLE.
  - E0 received in EXT, BRK or EXT_BRK: go to EXT, drop the pending prefix.
- **Make mapping (extended):** 75 up, 72 down, 6B left, 74 right.
- **Make mapping (non-extended):** 29 (space) pause.
- **Make codes:** a mapped make loads `kb_out` and pulses `kb_strobe`, even when the value is unchanged (typematic repeat). An unmapped make is ignored.
- **Break codes:** a break whose mapped code equals the current `kb_out` sets `kb_out` to 000 with no strobe. Other breaks are ignored.
- **Simultaneous keys:** the most recent make wins; releasing an older key does not clear `kb_out`.
- **Reset:** `clr` mid-frame clears the shift register, bit counter, idle counter, filter and FSM (-> IDLE).

## Timing
- **Reset values:** `kb_out` = 000, `kb_strobe` = 0, `frame_err` = 0. Filter output = 1, FSM = IDLE, counters = 0.
- **Input-to-edge latency:** 2 sync cycles plus `FILT_LEN` cycles from a raw `PS2C` fall to the internal edge.
- **Output latency:** `kb_out`, `kb_strobe` and `frame_err` update on the `clk` edge one cycle after the 11th falling edge is detected. All outputs are registered.
- **Strobe spacing:** at most one `kb_strobe` or `frame_err` per frame; the two never pulse together.
- **Bit counter:** wraps 10 -> 0 after frame completion, in the same cycle the byte is latched.
- **Timeout vs. edge:** a falling edge in the cycle the idle counter reaches `TIMEOUT_CYC` wins. The edge is shifted and the counter clears.

## Configuration
- **`PS2_WASD_EN` defined:** the non-extended makes/breaks 1D (W) up, 1B (S) down, 1C (A) left, 23 (D) right map exactly like the arrow keys, with the same break-clear rule.
- **`PS2_WASD_EN` undefined:** these codes are treated as unmapped and ignored.

## Test plan
- Reset asserted with `PS2C`/`PS2D` high -> `kb_out` = 000, no pulses for 1000 cycles.
- Frames E0, 75 -> `kb_out` = 001 and one `kb_strobe`, one cycle after the last falling edge. Then E0, F0, 75 -> `kb_out` = 000, no strobe.
- E0 6B, then E0 74, then E0 F0 6B -> `kb_out` = 100 throughout after the second make; the break of the older key is ignored.
- Frame 29 with the parity bit flipped -> one `frame_err`, `kb_out` unchanged. A correct 29 next -> `kb_out` = 101.
- 6 bits of a frame, then idle for `TIMEOUT_CYC` + 10 cycles, then a full frame E0, 72 -> `kb_out` = 010, no `frame_err`.
- Frame 1D: with `PS2_WASD_EN` -> `kb_out` = 001 and a strobe; without it -> `kb_out` stays 000, no strobe.

Source files
------------

// File: rtl/ps2_dir_decoder.sv
// -----------------------------------------------------------------------------
// ps2_dir_decoder
//
// PS/2 keyboard receiver feeding the snake game. It synchronizes and filters the
// raw PS/2 lines, deframes 11-bit scan-code frames, tracks the E0/F0 prefixes,
// and turns arrow/space key presses into a 3-bit direction code.
//
// Parameters
//   FILT_LEN     consecutive equal samples before the filtered PS/2 clock flips
//   TIMEOUT_CYC  clk cycles without a falling edge before a partial frame drops
//
// Ports
//   clk        in   system clock (the only clock)
//   clr        in   synchronous active-high reset
//   PS2C       in   raw PS/2 clock, asynchronous
//   PS2D       in   raw PS/2 data, asynchronous
//   kb_out     out  [2:0] 000 none, 001 up, 010 down, 011 left, 100 right, 101 pause
//   kb_strobe  out  one-cycle pulse on every kb_out load by a mapped make code
//   frame_err  out  one-cycle pulse on a start, parity or stop error
//
// Build option
//   PS2_WASD_EN  when defined, W/S/A/D (1D/1B/1C/23) act like the arrow keys.
// -----------------------------------------------------------------------------
module ps2_dir_decoder #(
   parameter int FILT_LEN    = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       PS2C,
   input  logic       PS2D,
   output logic [2:0] kb_out,
   output logic       kb_strobe,
   output logic       frame_err
);

   localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam int IW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYC);

   localparam logic [2:0] DIR_NONE  = 3'b000;
   localparam logic [2:0] DIR_UP    = 3'b001;
   localparam logic [2:0] DIR_DOWN  = 3'b010;
   localparam logic [2:0] DIR_LEFT  = 3'b011;
   localparam logic [2:0] DIR_RIGHT = 3'b100;
   localparam logic [2:0] DIR_PAUSE = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } state_t;

   // Synchronizers
   logic          r_c_s1, r_c_s2;
   logic          r_d_s1, r_d_s2;
   // Clock filter
   logic          r_filt_clk;
   logic [FW-1:0] r_filt_cnt;
   logic          r_fall;
   // Deframer
   logic [10:0]   r_shift;
   logic [3:0]    r_bit_cnt;
   logic [IW-1:0] r_idle_cnt;
   // Prefix FSM and outputs
   state_t        r_state;
   logic [2:0]    r_kb_out;
   logic          r_kb_strobe;
   logic          r_frame_err;

   logic [10:0]   w_frame;
   logic          w_frame_done;
   logic          w_frame_ok;
   logic [7:0]    w_byte;
   logic [2:0]    w_code_ext;
   logic [2:0]    w_code_std;

   // ---------------------------------------------------------------------------
   // Two-flop synchronizers; idle PS/2 lines are high, so reset to 1.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value;
      // blocking here would collapse the two-stage synchronizer into one stage.
      if (clr) begin
         r_c_s1 <= 1'b1;
         r_c_s2 <= 1'b1;
         r_d_s1 <= 1'b1;
         r_d_s2 <= 1'b1;
      end else begin
         r_c_s1 <= PS2C;
         r_c_s2 <= r_c_s1;
         r_d_s1 <= PS2D;
         r_d_s2 <= r_d_s1;
      end
   end

   // ---------------------------------------------------------------------------
   // Clock filter: the filtered level flips only after FILT_LEN consecutive
   // samples that disagree with it. r_fall marks the 1 -> 0 flip for one cycle.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (clr) begin
         r_filt_clk <= 1'b1;
         r_filt_cnt <= '0;
         r_fall     <= 1'b0;
      end else begin
         r_fall <= 1'b0;
         if (r_c_s2 != r_filt_clk) begin
            if (r_filt_cnt == FILT_MAX) begin
               r_filt_clk <= r_c_s2;
               r_filt_cnt <= '0;
               r_fall     <= ~r_c_s2;
            end else begin
               r_filt_cnt <= r_filt_cnt + 1'b1;
            end
         end else begin
            r_filt_cnt <= '0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Frame view including the bit arriving on this edge (bit 0 = start).
   // ---------------------------------------------------------------------------
   assign w_frame      = {r_d_s2, r_shift[10:1]};
   assign w_frame_done = r_fall && (r_bit_cnt == 4'd10);
   assign w_frame_ok   = ~w_frame[0] & (^w_frame[9:1]) & w_frame[10];
   assign w_byte       = w_frame[8:1];

   // ---------------------------------------------------------------------------
   // Scan-code maps; DIR_NONE means "not a direction key".
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: default first so every path assigns the outputs and no latch forms.
      w_code_ext = DIR_NONE;
      w_code_std = DIR_NONE;
      case (w_byte)
         8'h75:   w_code_ext = DIR_UP;
         8'h72:   w_code_ext = DIR_DOWN;
         8'h6B:   w_code_ext = DIR_LEFT;
         8'h74:   w_code_ext = DIR_RIGHT;
         default: w_code_ext = DIR_NONE;
      endcase
      case (w_byte)
         8'h29:   w_code_std = DIR_PAUSE;
`ifdef PS2_WASD_EN
         8'h1D:   w_code_std = DIR_UP;
         8'h1B:   w_code_std = DIR_DOWN;
         8'h1C:   w_code_std = DIR_LEFT;
         8'h23:   w_code_std = DIR_RIGHT;
`endif
         default: w_code_std = DIR_NONE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Deframer: shift on every filtered falling edge; a stalled partial frame is
   // dropped after TIMEOUT_CYC idle cycles. An edge always beats the timeout.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (clr) begin
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_idle_cnt <= '0;
      end else if (r_fall) begin
         r_shift    <= w_frame;
         r_bit_cnt  <= (r_bit_cnt == 4'd10) ? 4'd0 : r_bit_cnt + 4'd1;
         r_idle_cnt <= '0;
      end else if (r_bit_cnt != 4'd0) begin
         if (r_idle_cnt == IDLE_MAX) begin
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
         end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
         end
      end else begin
         r_idle_cnt <= '0;
      end
   end

   // ---------------------------------------------------------------------------
   // Prefix FSM with registered outputs. A bad frame leaves the prefix state
   // untouched; E0 always restarts an extended sequence.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (clr) begin
         r_state     <= ST_IDLE;
         r_kb_out    <= DIR_NONE;
         r_kb_strobe <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_kb_strobe <= 1'b0;
         r_frame_err <= 1'b0;
         if (w_frame_done) begin
            if (!w_frame_ok) begin
               r_frame_err <= 1'b1;
            end else if (w_byte == 8'hE0) begin
               r_state <= ST_EXT;
            end else begin
               case (r_state)
                  ST_IDLE: begin
                     if (w_byte == 8'hF0) begin
                        r_state <= ST_BRK;
                     end else if (w_code_std != DIR_NONE) begin
                        r_kb_out    <= w_code_std;
                        r_kb_strobe <= 1'b1;
                     end
                  end
                  ST_EXT: begin
                     if (w_byte == 8'hF0) begin
                        r_state <= ST_EXT_BRK;
                     end else begin
                        r_state <= ST_IDLE;
                        if (w_code_ext != DIR_NONE) begin
                           r_kb_out    <= w_code_ext;
                           r_kb_strobe <= 1'b1;
                        end
                     end
                  end
                  ST_BRK: begin
                     r_state <= ST_IDLE;
                     // Only releasing the key that owns kb_out clears it.
                     if (w_code_std != DIR_NONE && w_code_std == r_kb_out)
                        r_kb_out <= DIR_NONE;
                  end
                  default: begin
                     r_state <= ST_IDLE;
                     if (w_code_ext != DIR_NONE && w_code_ext == r_kb_out)
                        r_kb_out <= DIR_NONE;
                  end
               endcase
            end
         end
      end
   end

   assign kb_out    = r_kb_out;
   assign kb_strobe = r_kb_strobe;
   assign frame_err = r_frame_err;

endmodule
